// File: rtl/rr_arbiter.sv
// rr_arbiter: N-way round-robin arbiter with a registered one-hot grant held until ACK.
// Define ARB_BACKTOBACK_EN to re-grant on the ACK edge with no IDLE bubble.
module rr_arbiter #(
    parameter int N  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [N-1:0]  REQ,
    input  logic          ACK,
    output logic [N-1:0]  GNT,
    output logic          GNT_VALID,
    output logic [IW-1:0] GNT_IDX
);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t        state_q;
    logic [N-1:0]  gnt_q;
    logic          vld_q;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW-1:0] sel_ptr;
    logic [N-1:0]  masked;
    logic [N-1:0]  win;
    logic [IW-1:0] win_idx;

    // In HOLD the winner is evaluated against the post-ACK pointer (only used back-to-back).
    always_comb begin
        ptr_d   = (idx_q == IW'(N - 1)) ? '0 : idx_q + IW'(1);
        sel_ptr = (state_q == HOLD) ? ptr_d : ptr_q;
        masked  = REQ & ~((N'(1) << sel_ptr) - N'(1));
        win     = (masked != '0) ? (masked & ~(masked - N'(1))) : (REQ & ~(REQ - N'(1)));
        win_idx = '0;
        for (int i = 0; i < N; i++)
            if (win[i]) win_idx = IW'(i);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            vld_q   <= 1'b0;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else if (state_q == IDLE) begin
            if (REQ != '0) begin
                state_q <= HOLD;
                gnt_q   <= win;
                idx_q   <= win_idx;
                vld_q   <= 1'b1;
            end
        end else if (ACK) begin
            ptr_q <= ptr_d;
`ifdef ARB_BACKTOBACK_EN
            if (win != '0) begin
                gnt_q <= win;
                idx_q <= win_idx;
            end else begin
                state_q <= IDLE;
                gnt_q   <= '0;
                vld_q   <= 1'b0;
                idx_q   <= '0;
            end
`else
            state_q <= IDLE;
            gnt_q   <= '0;
            vld_q   <= 1'b0;
            idx_q   <= '0;
`endif
        end
    end

    assign GNT       = gnt_q;
    assign GNT_VALID = vld_q;
    assign GNT_IDX   = idx_q;

    assert property (@(posedge CLK) disable iff (RESET)
        (vld_q == (gnt_q != '0)) && (vld_q ? (gnt_q == (N'(1) << idx_q)) : (idx_q == '0)));
endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: directed plus randomized checks of rr_arbiter against a scan-order reference model.
module tb_rr_arbiter;
    localparam int N  = 8;
    localparam int IW = 3;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req = '0;
    logic          ack = 1'b0;
    logic [N-1:0]  gnt;
    logic          gnt_valid;
    logic [IW-1:0] gnt_idx;
    int            checks = 0;
    int            failures = 0;
    int            m_ptr = 0;
    int            m_idx = 0;
    bit            m_hold = 1'b0;

    rr_arbiter #(.N(N)) dut (
        .CLK(clk), .RESET(rst), .REQ(req), .ACK(ack),
        .GNT(gnt), .GNT_VALID(gnt_valid), .GNT_IDX(gnt_idx)
    );

    always #5 clk = ~clk;

    // First requester found scanning upward from p, wrapping at N; -1 if none.
    function automatic int pick(logic [N-1:0] r, int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [N-1:0] r;
        logic         a;
        logic         rs;
        int           w;
        r  = req;
        a  = ack;
        rs = rst;
        @(posedge clk);
        if (rs) begin
            m_hold = 1'b0;
            m_ptr  = 0;
            m_idx  = 0;
        end else if (!m_hold) begin
            w = pick(r, m_ptr);
            if (w >= 0) begin
                m_hold = 1'b1;
                m_idx  = w;
            end
        end else if (a) begin
            m_ptr = (m_idx + 1) % N;
`ifdef ARB_BACKTOBACK_EN
            w = pick(r, m_ptr);
            if (w >= 0) m_idx = w;
            else begin
                m_hold = 1'b0;
                m_idx  = 0;
            end
`else
            m_hold = 1'b0;
            m_idx  = 0;
`endif
        end
        #1;
        chk("gnt", 32'(gnt), m_hold ? (32'd1 << m_idx) : 32'd0);
        chk("gnt_valid", 32'(gnt_valid), 32'(m_hold));
        chk("gnt_idx", 32'(gnt_idx), m_hold ? 32'(m_idx) : 32'd0);
    endtask

    task automatic grant_next(logic [N-1:0] rv);
        ack = 1'b1;
        req = rv;
        tick();
        ack = 1'b0;
        if (!m_hold) tick();
    endtask

    initial begin
        rst = 1'b1;
        req = 8'hFF;
        tick();
        tick();
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_valid", 32'(gnt_valid), 32'h0);
        rst = 1'b0;
        tick();
        chk("first_gnt", 32'(gnt), 32'h01);
        chk("first_idx", 32'(gnt_idx), 32'h0);
        for (int g = 1; g <= 8; g++) begin
            grant_next(8'hFF);
            chk("rotation", 32'(gnt_idx), 32'(g % 8));
        end
        grant_next(8'h20);
        chk("grant5", 32'(gnt), 32'h20);
        grant_next(8'h0A);
        chk("masked_wrap", 32'(gnt), 32'h02);
        grant_next(8'h08);
        chk("ptr2_grant", 32'(gnt), 32'h08);
        req = '0;
        ack = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("hold", 32'(gnt), 32'h08);
        end
        ack = 1'b1;
        tick();
        chk("hold_release", 32'(gnt_valid), 32'h0);
        ack = 1'b0;
        req = 8'h18;
        tick();
        chk("ptr4_grant", 32'(gnt), 32'h10);
        ack = 1'b1;
        req = '0;
        tick();
        tick();
        chk("stray_ack", 32'(gnt), 32'h0);
        ack = 1'b0;
        req = 8'h21;
        tick();
        chk("ptr5_kept", 32'(gnt), 32'h20);
        rst = 1'b1;
        tick();
        chk("mid_reset", 32'(gnt), 32'h0);
        rst = 1'b0;
        tick();
        chk("post_reset", 32'(gnt), 32'h01);
        req = 8'h10;
        ack = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        ack = 1'b0;
        req = '0;
        tick();
        for (int c = 0; c < 600; c++) begin
            case ($urandom_range(0, 3))
                0: req = '0;
                1: req = N'($urandom) & N'($urandom);
                default: req = N'($urandom);
            endcase
            ack = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 63) == 0);
            tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
